mem_responder: RTL and testbench

Memory-side responder for the CPU's memory bus. It accepts read and write commands issued on `mem_cmd`/`mem_addr`/`write_data` and executes them against a 256-word RAM and, optionally, memory-mapped switch and LED registers. It returns `read_data` together with a one-cycle `mem_ack` after a programmable number of wait states. It sits between the CPU and the board I/O, and is the responding end of the CPU memory interface.

---
 rtl/mem_responder_if.sv | 19 +
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU memory bus between the requester (master) and mem_responder (slave).
// Carries command, address and store data out; load data and completion ack back.
interface mem_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ack;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ack
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ack
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 256x16 RAM plus optional LED/switch registers, with WAIT_STATES busy cycles.
// Optional feature macro: MEM_MMIO_EN (LED register at 0x100, switch port at 0x140).
module mem_responder #(
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  input  logic [7:0]      sw,
  output logic [7:0]      led
);

  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b10;
  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_SW  = 9'h140;
  localparam logic [2:0] CNT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESPOND} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [1:0]  r_cmd;
  logic [8:0]  r_addr;
  logic [15:0] r_wdata;

  logic [15:0] r_ram [0:255];
  logic [15:0] r_ram_q;
  logic [15:0] r_reg_rdata;
  logic        r_rd_from_ram;

  logic        w_req;
  logic        w_enter_respond;
  logic [1:0]  w_acc_cmd;
  logic [8:0]  w_acc_addr;
  logic [15:0] w_acc_wdata;
  logic        w_is_read;
  logic        w_is_write;
  logic        w_is_ram;
  logic [15:0] w_mmio_rdata;

  assign w_req = (bus.mem_cmd == MREAD) || (bus.mem_cmd == MWRITE);

  // With zero wait states the access completes on the sampling edge, so the live bus is the operand.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_enter_respond = 1'b0;
    w_acc_cmd       = r_cmd;
    w_acc_addr      = r_addr;
    w_acc_wdata     = r_wdata;
    case (r_state)
      S_IDLE: begin
        w_acc_cmd   = bus.mem_cmd;
        w_acc_addr  = bus.mem_addr;
        w_acc_wdata = bus.write_data;
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_next    = S_RESPOND;
            w_enter_respond = 1'b1;
          end else begin
            w_state_next = S_BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 3'd0) begin
          w_state_next    = S_RESPOND;
          w_enter_respond = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_RESPOND: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign w_is_read  = w_enter_respond && (w_acc_cmd == MREAD);
  assign w_is_write = w_enter_respond && (w_acc_cmd == MWRITE);
  assign w_is_ram   = ~w_acc_addr[8];

`ifdef MEM_MMIO_EN
  logic [7:0] r_led;

  always_comb begin
    w_mmio_rdata = 16'h0000;
    if (w_acc_addr == ADDR_SW)
      w_mmio_rdata = {8'h00, sw};
    else if (w_acc_addr == ADDR_LED)
      w_mmio_rdata = {8'h00, r_led};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_led <= 8'h00;
    else if (w_is_write && (w_acc_addr == ADDR_LED))
      r_led <= w_acc_wdata[7:0];
  end

  assign led = r_led;
`else
  wire w_unused_sw = ^sw;

  assign w_mmio_rdata = 16'h0000;
  assign led          = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_cmd   <= 2'b00;
      r_addr  <= 9'h000;
      r_wdata <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_cmd   <= bus.mem_cmd;
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.write_data;
      end
    end
  end

  // RAM has no reset; gating with reset keeps a coincident reset from committing the access.
  always_ff @(posedge clk) begin
    if (w_is_write && w_is_ram && !reset)
      r_ram[w_acc_addr[7:0]] <= w_acc_wdata;
    if (w_is_read && w_is_ram && !reset)
      r_ram_q <= r_ram[w_acc_addr[7:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_rdata   <= 16'h0000;
      r_rd_from_ram <= 1'b0;
    end else if (w_is_read) begin
      r_reg_rdata   <= w_mmio_rdata;
      r_rd_from_ram <= w_is_ram;
    end
  end

  assign bus.read_data = r_rd_from_ram ? r_ram_q : r_reg_rdata;
  assign bus.mem_ack   = (r_state == S_RESPOND);

endmodule

// File: tb/tb_mem_responder.sv
// Drives three responders (WAIT_STATES 0, 1, 3) with directed and random accesses
// and compares ack latency, read data and LED state against a transaction-level model.
module tb_mem_responder;

  localparam int NDUT = 3;
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
`ifdef MEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst = '0;
  logic [NDUT-1:0] drive;
  logic [1:0]      req_cmd;
  logic [8:0]      req_addr;
  logic [15:0]     req_wdata;
  logic [7:0]      sw;

  logic [15:0]     rd  [NDUT];
  logic [NDUT-1:0] ack;
  logic [7:0]      led [NDUT];

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    mem_responder_if bus ();
    assign bus.mem_cmd    = drive[gi] ? req_cmd : MNONE;
    assign bus.mem_addr   = req_addr;
    assign bus.write_data = req_wdata;
    assign rd[gi]         = bus.read_data;
    assign ack[gi]        = bus.mem_ack;

    mem_responder #(.WAIT_STATES(gi == 0 ? 0 : (gi == 1 ? 1 : 3))) u_dut (
      .clk   (clk),
      .reset (rst[gi]),
      .bus   (bus.slave),
      .sw    (sw),
      .led   (led[gi])
    );
  end

  // Transaction-level reference state
  logic [15:0] m_ram   [256];
  bit          m_known [256];
  logic [15:0] m_rd    [NDUT];
  logic [7:0]  m_led   [NDUT];

  int n_checks = 0;
  int n_err    = 0;
  int n_txn    = 0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic logic [15:0] model_read(input int k, input logic [8:0] a);
    if (!a[8])                 return m_ram[a[7:0]];
    if (MMIO && a == 9'h100)   return {8'h00, m_led[k]};
    if (MMIO && a == 9'h140)   return {8'h00, sw};
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // One request held until each selected DUT acks; everything is judged after a fixed window.
  task automatic run_txn(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d,
                         input logic [NDUT-1:0] mask);
    int          lat   [NDUT];
    int          extra [NDUT];
    logic [15:0] rdv   [NDUT];
    logic [7:0]  ledv  [NDUT];
    bit          is_acc;
    is_acc = (cmd == MREAD) || (cmd == MWRITE);
    for (int k = 0; k < NDUT; k++) begin
      lat[k] = 0; extra[k] = 0; rdv[k] = 16'h0; ledv[k] = 8'h0;
    end
    n_txn++;
    $display("txn %0d cmd=%b addr=%h wdata=%h sw=%h mask=%b", n_txn, cmd, a, d, sw, mask);
    req_cmd = cmd; req_addr = a; req_wdata = d; drive = mask;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (ack[k]) begin
          if (drive[k] && lat[k] == 0) begin
            lat[k] = n; rdv[k] = rd[k]; ledv[k] = led[k]; drive[k] = 1'b0;
          end else begin
            extra[k]++;
          end
        end
      end
    end
    drive = '0;
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        if (cmd == MREAD)
          m_rd[k] = model_read(k, a);
        if (cmd == MWRITE && MMIO && a == 9'h100)
          m_led[k] = d[7:0];
      end
    end
    if (cmd == MWRITE && !a[8]) begin
      m_ram[a[7:0]] = d;
      m_known[a[7:0]] = 1'b1;
    end
    for (int k = 0; k < NDUT; k++) begin
      if (mask[k]) begin
        if (is_acc) begin
          check("ack_latency", k, 32'(lat[k]), 32'(ws_of(k) + 1));
          check("rdata_at_ack", k, 32'(rdv[k]), 32'(m_rd[k]));
          check("led_at_ack", k, 32'(ledv[k]), 32'(m_led[k]));
        end else begin
          check("no_ack", k, 32'(lat[k]), 32'd0);
        end
        check("extra_ack", k, 32'(extra[k]), 32'd0);
        check("rdata_hold", k, 32'(rd[k]), 32'(m_rd[k]));
      end
    end
  endtask

  // MREAD held for 6 cycles: each IDLE sample starts a fresh access.
  task automatic held_read(input logic [8:0] a);
    int cnt [NDUT];
    int first [NDUT];
    int second [NDUT];
    for (int k = 0; k < NDUT; k++) begin
      cnt[k] = 0; first[k] = 0; second[k] = 0;
    end
    n_txn++;
    $display("txn %0d held MREAD addr=%h for 6 cycles", n_txn, a);
    req_cmd = MREAD; req_addr = a; req_wdata = 16'h0; drive = '1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 6) drive = '0;
      for (int k = 0; k < NDUT; k++) begin
        if (ack[k]) begin
          cnt[k]++;
          if (cnt[k] == 1) first[k] = n;
          else if (cnt[k] == 2) second[k] = n;
          check("held_rdata", k, 32'(rd[k]), 32'(model_read(k, a)));
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      m_rd[k] = model_read(k, a);
      check("held_ack_count", k, 32'(cnt[k]), 32'(1 + 5 / (ws_of(k) + 2)));
      check("held_first_ack", k, 32'(first[k]), 32'(ws_of(k) + 1));
      check("held_ack_spacing", k, 32'(second[k] - first[k]), 32'(ws_of(k) + 2));
    end
  endtask

  initial begin
    int acks;
    int sel;
    logic [1:0]  cmd;
    logic [8:0]  a;
    logic [15:0] d;

    drive = '0; req_cmd = MNONE; req_addr = '0; req_wdata = '0; sw = 8'h00;
    for (int i = 0; i < 256; i++) begin
      m_ram[i] = 16'h0; m_known[i] = 1'b0;
    end
    for (int k = 0; k < NDUT; k++) begin
      m_rd[k] = 16'h0; m_led[k] = 8'h0;
    end

    #1 rst = '1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("reset_ack", k, 32'(ack[k]), 32'd0);
      check("reset_rdata", k, 32'(rd[k]), 32'd0);
      check("reset_led", k, 32'(led[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = '0;

    // RAM write/read, zero-wait-state read at top of RAM
    run_txn(MWRITE, 9'h012, 16'hBEEF, '1);
    run_txn(MREAD,  9'h012, 16'h0000, '1);
    run_txn(MWRITE, 9'h0FF, 16'h1234, '1);
    run_txn(MREAD,  9'h0FF, 16'h0000, '1);

    // Unmapped address
    run_txn(MWRITE, 9'h1A0, 16'hFFFF, '1);
    run_txn(MREAD,  9'h1A0, 16'h0000, '1);

    // LED and switch registers
    run_txn(MWRITE, 9'h100, 16'h00A5, '1);
    sw = 8'h3C;
    run_txn(MREAD,  9'h140, 16'h0000, '1);
    run_txn(MREAD,  9'h100, 16'h0000, '1);

    // Reset during BUSY on the 3-wait-state responder
    run_txn(MWRITE, 9'h005, 16'h1111, '1);
    n_txn++;
    $display("txn %0d MWRITE addr=005 wdata=7777 to dut2, reset during BUSY", n_txn);
    req_cmd = MWRITE; req_addr = 9'h005; req_wdata = 16'h7777; drive = 3'b100;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("busy_no_ack", 2, 32'(ack[2]), 32'd0);
    rst[2] = 1'b1;
    #1;
    check("busy_reset_rdata", 2, 32'(rd[2]), 32'd0);
    check("busy_reset_ack", 2, 32'(ack[2]), 32'd0);
    check("busy_reset_led", 2, 32'(led[2]), 32'd0);
    m_rd[2] = 16'h0; m_led[2] = 8'h0;
    @(negedge clk);
    @(negedge clk);
    drive = '0; rst[2] = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (ack[2]) acks++;
    end
    check("aborted_write_ack", 2, 32'(acks), 32'd0);
    run_txn(MREAD, 9'h005, 16'h0000, '1);

    // Illegal command, then a normal access to confirm IDLE was kept
    run_txn(2'b11, 9'h012, 16'h5555, '1);
    run_txn(MREAD, 9'h0FF, 16'h0000, '1);

    held_read(9'h012);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 9));
      cmd = (sel < 4) ? MWRITE : (sel < 8) ? MREAD : (sel == 8) ? MNONE : 2'b11;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1, 2: a = 9'($urandom_range(0, 15));
        3:       a = 9'h100;
        4:       a = 9'h140;
        default: a = {1'b1, 8'($urandom_range(0, 255))};
      endcase
      if (cmd == MREAD && !a[8] && !m_known[a[7:0]])
        cmd = MWRITE;
      d  = 16'($urandom);
      sw = 8'($urandom);
      run_txn(cmd, a, d, '1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
